// File: rtl/reg_sequencer_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : reg_sequencer_pkg
//  Description : Shared encodings for the register sequencer and the 4-bit
//                register it drives: register function codes, command opcodes,
//                sequencer state encoding and the register next-value rule.
//  Revision    : 1.0 - initial release
// ============================================================================
package reg_sequencer_pkg;

  // Function codes presented to the 4-bit register. Codes 101-111 are unused.
  typedef enum logic [2:0] {
    FUNC_CLEAR = 3'b000,
    FUNC_LOAD  = 3'b001,
    FUNC_HOLD  = 3'b010,
    FUNC_SL    = 3'b011,
    FUNC_SR    = 3'b100
  } func_e;

  // Requester command opcodes.
  typedef enum logic [1:0] {
    OP_CLEAR = 2'b00,
    OP_LOAD  = 2'b01,
    OP_SHL   = 2'b10,
    OP_SHR   = 2'b11
  } op_e;

  // Sequencer states.
  typedef enum logic [1:0] {
    ST_INIT = 2'b00,
    ST_IDLE = 2'b01,
    ST_RUN  = 2'b10,
    ST_DONE = 2'b11
  } state_e;

  // Value the register takes on an edge given the function and load data
  // presented during the preceding cycle.
  function automatic logic [3:0] next_reg_value(
    input func_e      f,
    input logic [3:0] cur,
    input logic [3:0] din
  );
    logic [3:0] nxt;
    nxt = cur;
    case (f)
      FUNC_CLEAR: nxt = 4'b0000;
      FUNC_LOAD:  nxt = din;
      FUNC_SL:    nxt = {cur[2:0], 1'b0};
      FUNC_SR:    nxt = {1'b0, cur[3:1]};
      default:    nxt = cur;
    endcase
    return nxt;
  endfunction

endpackage
`default_nettype wire

// File: rtl/reg_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : reg_sequencer
//  Description : Sequences clear / load / shift commands onto a 4-bit
//                register's function and data inputs, and keeps a shadow copy
//                of the register contents.
//  Ports       : clk, rst_n (async, active-low)
//                cmd_valid/cmd_ready  - command handshake (accept in IDLE)
//                cmd_op/amt/data      - opcode, shift count, load value
//                func, reg_in         - register function code and load data
//                shadow               - register contents after the last edge
//                busy, done           - RUN indicator, one-cycle completion
//  Revision    : 1.0 - initial release
// ============================================================================
module reg_sequencer
  import reg_sequencer_pkg::*;
#(
  parameter int MAX_SHIFT = 4   // clamp for shift count; must be 0..7
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic [1:0] cmd_op,
  input  logic [2:0] cmd_amt,
  input  logic [3:0] cmd_data,
  output logic [2:0] func,
  output logic [3:0] reg_in,
  output logic [3:0] shadow,
  output logic       busy,
  output logic       done
);

  localparam logic [2:0] MAX_CNT = 3'(MAX_SHIFT);

  state_e     state_q,  state_d;
  func_e      func_q,   func_d;
  logic [3:0] reg_in_q, reg_in_d;
  logic [3:0] shadow_q, shadow_d;
  logic [2:0] cnt_q,    cnt_d;
  logic       busy_q,   busy_d;
  logic       done_q,   done_d;

  logic [2:0] amt_clamped;
  logic [2:0] shift_cnt_init;

  assign amt_clamped    = (cmd_amt > MAX_CNT) ? MAX_CNT : cmd_amt;
  // cnt holds the number of RUN cycles remaining after the current one, so a
  // zero-length shift still gets its single HOLD cycle with cnt = 0.
  assign shift_cnt_init = (amt_clamped == 3'd0) ? 3'd0 : amt_clamped - 3'd1;

  assign cmd_ready = (state_q == ST_IDLE);

  always_comb begin
    state_d  = state_q;
    func_d   = func_q;
    reg_in_d = reg_in_q;
    cnt_d    = cnt_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    // Shadow tracks the register: it applies the function on the same edge.
    shadow_d = next_reg_value(func_q, shadow_q, reg_in_q);

    unique case (state_q)
      ST_INIT: begin
        state_d = ST_IDLE;
        func_d  = FUNC_HOLD;
      end
      ST_IDLE: begin
        func_d = FUNC_HOLD;
        if (cmd_valid) begin
          state_d = ST_RUN;
          busy_d  = 1'b1;
          cnt_d   = 3'd0;
          case (op_e'(cmd_op))
            OP_CLEAR: func_d = FUNC_CLEAR;
            OP_LOAD: begin
              func_d   = FUNC_LOAD;
              reg_in_d = cmd_data;
            end
            OP_SHL: begin
              func_d = (amt_clamped == 3'd0) ? FUNC_HOLD : FUNC_SL;
              cnt_d  = shift_cnt_init;
            end
            OP_SHR: begin
              func_d = (amt_clamped == 3'd0) ? FUNC_HOLD : FUNC_SR;
              cnt_d  = shift_cnt_init;
            end
          endcase
        end
      end
      ST_RUN: begin
        if (cnt_q == 3'd0) begin
          state_d = ST_DONE;
          func_d  = FUNC_HOLD;
          busy_d  = 1'b0;
          done_d  = 1'b1;
        end else begin
          cnt_d = cnt_q - 3'd1;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
        func_d  = FUNC_HOLD;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_INIT;
      func_q   <= FUNC_CLEAR;
      reg_in_q <= 4'b0000;
      shadow_q <= 4'b0000;
      cnt_q    <= 3'd0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      func_q   <= func_d;
      reg_in_q <= reg_in_d;
      shadow_q <= shadow_d;
      cnt_q    <= cnt_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  assign func   = func_q;
  assign reg_in = reg_in_q;
  assign shadow = shadow_q;
  assign busy   = busy_q;
  assign done   = done_q;

endmodule
`default_nettype wire

// File: doc/reg_sequencer.md
REG_SEQUENCER -- requirements
Module: reg_sequencer

Interface
REQ-001 SHALL have parameter MAX_SHIFT, default 4, the clamp for shift count (register width).
REQ-002 SHALL have port clk  input  1  single rising-edge clock.
REQ-003 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port cmd_valid  input  1  requester presents a command.
REQ-005 SHALL have port cmd_ready  output  1  sequencer accepts a command this cycle.
REQ-006 SHALL have port cmd_op  input  2  command: 00 clear, 01 load, 10 shift left, 11 shift right.
REQ-007 SHALL have port cmd_amt  input  3  shift count; ignored for clear/load.
REQ-008 SHALL have port cmd_data  input  4  load value; ignored for other ops.
REQ-009 SHALL have port func  output  3  function code to the 4-bit register (000 CLEAR, 001 LOAD, 010 HOLD, 011 SL, 100 SR).
REQ-010 SHALL have port reg_in  output  4  data to the register's load input.
REQ-011 SHALL have port shadow  output  4  value the register holds after the current edge's update.
REQ-012 SHALL have port busy  output  1  command in progress.
REQ-013 SHALL have port done  output  1  one-cycle completion pulse.

Function
REQ-014 SHALL implement states INIT, IDLE, RUN, DONE; func, reg_in, shadow, done and busy SHALL be registered.
REQ-015 INIT SHALL drive func=CLEAR for exactly one cycle, then go to IDLE.
REQ-016 IDLE SHALL drive func=HOLD and cmd_ready=1; cmd_ready SHALL be 0 in every other state.
REQ-017 A command SHALL be accepted on the edge where cmd_valid=1 and cmd_ready=1; op, data and the clamped count SHALL be captured on that edge.
REQ-018 Accepted clear/load SHALL drive func=CLEAR or LOAD, with reg_in=cmd_data for load, for exactly one cycle in RUN.
REQ-019 An accepted shift SHALL drive func=SL or SR for N consecutive RUN cycles, N=min(cmd_amt, MAX_SHIFT).
REQ-020 A shift with cmd_amt=0 SHALL spend one RUN cycle with func=HOLD.
REQ-021 After the last RUN cycle the FSM SHALL enter DONE for one cycle: func=HOLD, done=1, busy=0; it SHALL then return to IDLE.
REQ-022 Latency SHALL be: accept at edge E; RUN cycles E+1..E+N (N>=1); done high in cycle E+N+1; next accept no earlier than edge E+N+2.
REQ-023 busy SHALL be 1 exactly during RUN cycles.
REQ-024 shadow SHALL update on the same edge as the register: CLEAR->0, LOAD->reg_in, SL->shadow<<1 truncated to 4 bits, SR->shadow>>1 with zero fill, HOLD->unchanged.
REQ-025 func SHALL never take values 101-111.
REQ-026 cmd_valid outside IDLE SHALL be ignored; the requester holds the command until accepted.

Reset
REQ-027 While rst_n=0: state=INIT, func=CLEAR, reg_in=0, shadow=0, busy=0, done=0, cmd_ready=0; this holds the register clear on every edge under reset.
REQ-028 Reset asserted mid-command SHALL abort it immediately, with no done pulse; after release the sequence restarts at INIT.

Structure
REQ-029 Func codes (CLEAR..SR), cmd_op encodings and state encodings SHALL live in a shared package used by this block and the register.
REQ-030 The shift counter SHALL be a 3-bit down-counter inside this module; the only natural sub-module is the register itself (instantiated at the parent level, not inside this block).

Verification
REQ-031 Release reset -> one cycle func=CLEAR, then func=HOLD, cmd_ready=1, shadow=0.
REQ-032 Load 4'b1011 -> one RUN cycle func=LOAD, reg_in=1011; done next cycle; shadow=1011.
REQ-033 Shadow=0001, shift left amt=3 -> three SL cycles, shadow 0010, 0100, 1000; done in cycle E+4.
REQ-034 Shadow=1111, shift right amt=7 -> clamped to four SR cycles; shadow=0000; busy high 4 cycles.
REQ-035 Shift amt=0 -> one HOLD RUN cycle, done pulse, shadow unchanged.
REQ-036 rst_n low during second SL of a 3-shift command -> func=CLEAR immediately, no done pulse, shadow=0, INIT after release.
